pipe_valid_tracker: RTL and testbench

//  Owns per-stage valid bits of the 7-stage pipe (F1,F2,DE,EX,M1,M2,WB) and produces the *_is_a_inst

---
 rtl/pipe_valid_tracker.sv | 151 +++++++++++++++
 tb/tb_pipe_valid_tracker.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_valid_tracker.sv
// Per-stage valid tracking for the 7-stage pipe (F1,F2,DE,EX,M1,M2,WB) with stall/flush/redirect/freeze,
// retire pulse, drain flag and stall watchdog. Optional perf counters under `PIPE_PERF_CNT_EN.
module pipe_valid_tracker #(
    parameter int STALL_TIMEOUT = 64,
    parameter int WDT_W         = 8,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fetch_valid,
    input  logic             mem_freeze,
    input  logic             redirect_ex,
    input  logic             stall_pc,
    input  logic             stall_f2,
    input  logic             stall_de,
    input  logic             stall_ex,
    input  logic             flush_ex,
    input  logic             flush_m1,
    output logic             f1_valid,
    output logic             f2_valid,
    output logic             de_valid,
    output logic             ex_is_a_inst,
    output logic             m1_is_a_inst,
    output logic             m2_is_a_inst,
    output logic             wb_is_a_inst,
    output logic             redirect_take,
    output logic             rear_empty,
    output logic             instret,
    output logic             deadlock_err,
    output logic [CNT_W-1:0] perf_cycles,
    output logic [CNT_W-1:0] perf_instret,
    output logic [CNT_W-1:0] perf_stall,
    output logic [CNT_W-1:0] perf_bubble
);

    localparam logic [WDT_W-1:0] WDT_MAX = WDT_W'(STALL_TIMEOUT);

    logic f1_q, f2_q, de_q, ex_q, m1_q, m2_q, wb_q;
    logic f1_d, f2_d, de_d, ex_d, m1_d, m2_d, wb_d;
    logic [WDT_W-1:0] wdt_q, wdt_d;
    logic dl_q, dl_d;

    assign redirect_take = redirect_ex & ex_q & ~stall_ex & ~mem_freeze;
    assign instret       = wb_q & ~mem_freeze;
    assign rear_empty    = ~(ex_q | m1_q | m2_q | wb_q);

    assign f1_valid     = f1_q;
    assign f2_valid     = f2_q;
    assign de_valid     = de_q;
    assign ex_is_a_inst = ex_q;
    assign m1_is_a_inst = m1_q;
    assign m2_is_a_inst = m2_q;
    assign wb_is_a_inst = wb_q;
    assign deadlock_err = dl_q;

    always_comb begin
        f1_d = f1_q;
        f2_d = f2_q;
        de_d = de_q;
        ex_d = ex_q;
        m1_d = m1_q;
        m2_d = m2_q;
        wb_d = wb_q;
        if (!mem_freeze) begin
            // A stage that is not stalled takes its predecessor, or a bubble if the predecessor is held.
            if (!stall_pc) f1_d = fetch_valid;
            if (!stall_f2) f2_d = stall_pc ? 1'b0 : f1_q;
            if (!stall_de) de_d = stall_f2 ? 1'b0 : f2_q;
            if (!stall_ex) ex_d = stall_de ? 1'b0 : de_q;
            if (flush_ex)  ex_d = 1'b0;
            m1_d = (flush_m1 | stall_ex) ? 1'b0 : ex_q;
            m2_d = m1_q;
            wb_d = m2_q;
            if (redirect_take) begin
                f1_d = 1'b0;
                f2_d = 1'b0;
                de_d = 1'b0;
            end
        end
    end

    always_comb begin
        wdt_d = wdt_q;
        dl_d  = dl_q;
        if (!mem_freeze) begin
            if (stall_pc) begin
                if (wdt_q != WDT_MAX) wdt_d = wdt_q + 1'b1;
                if (wdt_q == WDT_MAX - 1'b1) dl_d = 1'b1;
            end else begin
                wdt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f1_q  <= 1'b0;
            f2_q  <= 1'b0;
            de_q  <= 1'b0;
            ex_q  <= 1'b0;
            m1_q  <= 1'b0;
            m2_q  <= 1'b0;
            wb_q  <= 1'b0;
            wdt_q <= '0;
            dl_q  <= 1'b0;
        end else begin
            f1_q  <= f1_d;
            f2_q  <= f2_d;
            de_q  <= de_d;
            ex_q  <= ex_d;
            m1_q  <= m1_d;
            m2_q  <= m2_d;
            wb_q  <= wb_d;
            wdt_q <= wdt_d;
            dl_q  <= dl_d;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] cyc_q, ret_q, stl_q, bub_q;
    logic             bubble_ev;

    // Several bubble sources in one cycle still count as a single event.
    assign bubble_ev = (flush_ex | flush_m1 | redirect_take) & ~mem_freeze;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q <= '0;
            ret_q <= '0;
            stl_q <= '0;
            bub_q <= '0;
        end else begin
            cyc_q <= cyc_q + 1'b1;
            if (instret) ret_q <= ret_q + 1'b1;
            if (stall_pc && !mem_freeze) stl_q <= stl_q + 1'b1;
            if (bubble_ev) bub_q <= bub_q + 1'b1;
        end
    end

    assign perf_cycles  = cyc_q;
    assign perf_instret = ret_q;
    assign perf_stall   = stl_q;
    assign perf_bubble  = bub_q;
`else
    assign perf_cycles  = '0;
    assign perf_instret = '0;
    assign perf_stall   = '0;
    assign perf_bubble  = '0;
`endif

endmodule

// File: tb/tb_pipe_valid_tracker.sv
// Directed bench for pipe_valid_tracker: fill, load-use stalls, redirect, freeze, watchdog, async reset, perf.
module tb_pipe_valid_tracker;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst_n, fetch_valid, mem_freeze, redirect_ex;
    logic stall_pc, stall_f2, stall_de, stall_ex, flush_ex, flush_m1;
    logic f1_valid, f2_valid, de_valid, ex_is_a_inst, m1_is_a_inst, m2_is_a_inst, wb_is_a_inst;
    logic redirect_take, rear_empty, instret, deadlock_err;
    logic [CNT_W-1:0] perf_cycles, perf_instret, perf_stall, perf_bubble;
    logic [6:0] vv;
    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign vv = {f1_valid, f2_valid, de_valid, ex_is_a_inst, m1_is_a_inst, m2_is_a_inst, wb_is_a_inst};

    pipe_valid_tracker #(.STALL_TIMEOUT(64), .WDT_W(8), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_valid(fetch_valid), .mem_freeze(mem_freeze),
        .redirect_ex(redirect_ex), .stall_pc(stall_pc), .stall_f2(stall_f2), .stall_de(stall_de),
        .stall_ex(stall_ex), .flush_ex(flush_ex), .flush_m1(flush_m1),
        .f1_valid(f1_valid), .f2_valid(f2_valid), .de_valid(de_valid), .ex_is_a_inst(ex_is_a_inst),
        .m1_is_a_inst(m1_is_a_inst), .m2_is_a_inst(m2_is_a_inst), .wb_is_a_inst(wb_is_a_inst),
        .redirect_take(redirect_take), .rear_empty(rear_empty), .instret(instret),
        .deadlock_err(deadlock_err), .perf_cycles(perf_cycles), .perf_instret(perf_instret),
        .perf_stall(perf_stall), .perf_bubble(perf_bubble)
    );

    task automatic clr_in();
        fetch_valid = 0; mem_freeze = 0; redirect_ex = 0;
        stall_pc = 0; stall_f2 = 0; stall_de = 0; stall_ex = 0; flush_ex = 0; flush_m1 = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr_in();
        rst_n = 0;
        #2;
        checks++;
        if (vv !== 7'b0 || deadlock_err !== 1'b0 || rear_empty !== 1'b1 || instret !== 1'b0 || redirect_take !== 1'b0) begin
            errs++;
            $display("FAIL reset: valids=%b dl=%b empty=%b ret=%b rt=%b, want 0000000 0 1 0 0",
                     vv, deadlock_err, rear_empty, instret, redirect_take);
        end
        checks++;
        if ({perf_cycles, perf_instret, perf_stall, perf_bubble} !== '0) begin
            errs++; $display("FAIL reset_perf: got %h want 0", {perf_cycles, perf_instret, perf_stall, perf_bubble});
        end
        step();
        rst_n = 1;
    endtask

    task automatic test_fill();
        fetch_valid = 1;
        for (int i = 1; i <= 6; i++) step();
        checks++;
        if (vv !== 7'b1111110) begin errs++; $display("FAIL fill_c6: got %b want 1111110", vv); end
        step();
        checks++;
        if (vv !== 7'b1111111) begin errs++; $display("FAIL fill_c7: got %b want 1111111", vv); end
        checks++;
        if (rear_empty !== 1'b0) begin errs++; $display("FAIL fill_empty: got %b want 0", rear_empty); end
        for (int i = 8; i <= 10; i++) begin
            checks++;
            if (instret !== 1'b1) begin errs++; $display("FAIL fill_instret c%0d: got %b want 1", i, instret); end
            step();
        end
    endtask

    task automatic test_load_use_ex();
        stall_pc = 1; stall_f2 = 1; stall_de = 1; stall_ex = 1; flush_m1 = 1;
        step();
        clr_in(); fetch_valid = 1;
        checks++;
        if (vv !== 7'b1111011) begin errs++; $display("FAIL lu_ex: got %b want 1111011", vv); end
        step();
        checks++;
        if (vv !== 7'b1111101) begin errs++; $display("FAIL lu_ex_nodup: got %b want 1111101", vv); end
        step(); step();
        checks++;
        if (vv !== 7'b1111111) begin errs++; $display("FAIL lu_ex_refill: got %b want 1111111", vv); end
    endtask

    task automatic test_load_use_de();
        stall_pc = 1; stall_f2 = 1; stall_de = 1; flush_ex = 1;
        step();
        clr_in(); fetch_valid = 1;
        checks++;
        if (vv !== 7'b1110111) begin errs++; $display("FAIL lu_de: got %b want 1110111", vv); end
    endtask

    task automatic test_freeze();
        clr_in(); mem_freeze = 1; flush_ex = 1; flush_m1 = 1; redirect_ex = 1;
        #1;
        checks++;
        if (instret !== 1'b0 || redirect_take !== 1'b0) begin
            errs++; $display("FAIL freeze_comb: ret=%b rt=%b want 0 0", instret, redirect_take);
        end
        step();
        checks++;
        if (vv !== 7'b1110111) begin errs++; $display("FAIL freeze_hold: got %b want 1110111", vv); end
        clr_in();
        for (int i = 0; i < 7; i++) step();
        checks++;
        if (vv !== 7'b0 || rear_empty !== 1'b1) begin
            errs++; $display("FAIL drain: got %b empty=%b want 0000000 1", vv, rear_empty);
        end
    endtask

    task automatic test_redirect();
        fetch_valid = 1;
        for (int i = 0; i < 4; i++) step();
        redirect_ex = 1; stall_de = 1;
        #1;
        checks++;
        if (redirect_take !== 1'b1) begin errs++; $display("FAIL redirect_take: got %b want 1", redirect_take); end
        step();
        checks++;
        if (vv !== 7'b0000100) begin errs++; $display("FAIL redirect_kill: got %b want 0000100", vv); end
        stall_de = 0;
        #1;
        checks++;
        if (redirect_take !== 1'b0) begin errs++; $display("FAIL redirect_noex: got %b want 0", redirect_take); end
        redirect_ex = 0;
        for (int i = 0; i < 4; i++) step();
        redirect_ex = 1; stall_ex = 1;
        #1;
        checks++;
        if (redirect_take !== 1'b0) begin errs++; $display("FAIL redirect_stalled: got %b want 0", redirect_take); end
        clr_in();
    endtask

    task automatic test_watchdog();
        test_reset();
        stall_pc = 1;
        for (int i = 1; i <= 67; i++) begin
            mem_freeze = (i == 10 || i == 20 || i == 30);
            step();
            if (i == 66) begin
                checks++;
                if (deadlock_err !== 1'b0) begin errs++; $display("FAIL wdt_early: got %b want 0", deadlock_err); end
            end
        end
        checks++;
        if (deadlock_err !== 1'b1) begin errs++; $display("FAIL wdt_set: got %b want 1", deadlock_err); end
        clr_in();
        step(); step();
        checks++;
        if (deadlock_err !== 1'b1) begin errs++; $display("FAIL wdt_sticky: got %b want 1", deadlock_err); end
    endtask

    task automatic test_async_reset();
        fetch_valid = 1;
        for (int i = 0; i < 5; i++) step();
        rst_n = 0;
        #2;
        checks++;
        if (vv !== 7'b0 || deadlock_err !== 1'b0) begin
            errs++; $display("FAIL async_reset: got %b dl=%b want 0000000 0", vv, deadlock_err);
        end
        clr_in();
        step();
        rst_n = 1;
    endtask

    task automatic test_perf();
`ifdef PIPE_PERF_CNT_EN
        test_reset();
        for (int i = 0; i < 15; i++) step();
        checks++;
        if (perf_cycles !== 4'hF) begin errs++; $display("FAIL perf_ones: got %h want f", perf_cycles); end
        step();
        checks++;
        if (perf_cycles !== 4'h0) begin errs++; $display("FAIL perf_wrap: got %h want 0", perf_cycles); end
        stall_pc = 1; flush_ex = 1; flush_m1 = 1;
        step();
        mem_freeze = 1;
        step();
        checks++;
        if (perf_stall !== 4'h1 || perf_bubble !== 4'h1 || perf_cycles !== 4'h2) begin
            errs++; $display("FAIL perf_freeze: stall=%h bub=%h cyc=%h want 1 1 2", perf_stall, perf_bubble, perf_cycles);
        end
        clr_in();
`else
        stall_pc = 1; flush_ex = 1; fetch_valid = 1;
        step(); step();
        checks++;
        if ({perf_cycles, perf_instret, perf_stall, perf_bubble} !== '0) begin
            errs++; $display("FAIL perf_off: got %h want 0", {perf_cycles, perf_instret, perf_stall, perf_bubble});
        end
        clr_in();
`endif
    endtask

    initial begin
        test_reset();
        test_fill();
        test_load_use_ex();
        test_load_use_de();
        test_freeze();
        test_redirect();
        test_watchdog();
        test_async_reset();
        test_perf();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
